rs_stream_checker: RTL and testbench

Parametrised, synthesizable self-checking comparator for the RS decoder datapath. It buffers the reference message symbols fed into the encoder/channel model, aligns them against the RS decoder output, and reports per-symbol mismatches, per-codeword error counts and running totals. It replaces file-based output dumping with on-chip pass/fail statistics, and runs in both simulation and FPGA bring-up next to the RS decoder.

---
 rtl/rs_stream_checker.sv | 134 +++++++++++++
 tb/tb_rs_stream_checker.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_stream_checker.sv
// Reference FIFO: circular buffer with wrap-bit pointers; a push into a full buffer succeeds only alongside a pop.
// Latency: a symbol written on edge n is readable at the head from edge n+1; the head read is combinational.
// Backpressure: none; a rejected push is reported through full, and a pop from empty is ignored.
module rs_sc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 256
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop_vld && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign push_ok = push_vld && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// Aligns decoded RS symbols against buffered reference symbols and keeps per-codeword and running error statistics.
// Latency: 1 cycle from dut_valid to sym_err / cw_done / counter updates.
// Backpressure: none; overflow and underflow are flagged on sticky ovf / udf.
module rs_stream_checker #(
    parameter int SYM_W = 8,
    parameter int K     = 188,
    parameter int DEPTH = 256,
    parameter int CNT_W = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     ref_valid,
    input  logic [SYM_W-1:0]         ref_sym,
    input  logic                     dut_valid,
    input  logic [SYM_W-1:0]         dut_sym,
    output logic                     sym_err,
    output logic                     cw_done,
    output logic [$clog2(K+1)-1:0]   cw_err_cnt,
    output logic [CNT_W-1:0]         total_cw,
    output logic [CNT_W-1:0]         total_bad_cw,
    output logic [CNT_W-1:0]         total_sym_err,
    output logic                     ovf,
    output logic                     udf
);
    localparam int ERR_W = $clog2(K+1);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    logic [SYM_W-1:0] ref_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] sym_idx;
    logic [ERR_W-1:0] cw_acc;
    logic [ERR_W-1:0] acc_next;
    logic             mis;
    logic             last;

    rs_sc_fifo #(
        .W     (SYM_W),
        .DEPTH (DEPTH)
    ) u_ref_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push_vld (ref_valid),
        .push_dat (ref_sym),
        .pop_vld  (dut_valid),
        .pop_dat  (ref_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // An underflowing pop has nothing to compare against, so it counts as a mismatch.
    assign mis      = dut_valid && (fifo_empty || (ref_head != dut_sym));
    assign last     = dut_valid && (sym_idx == IDX_W'(K-1));
    assign acc_next = cw_acc + ERR_W'(mis);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sym_err       <= 1'b0;
            cw_done       <= 1'b0;
            cw_err_cnt    <= '0;
            total_cw      <= '0;
            total_bad_cw  <= '0;
            total_sym_err <= '0;
            ovf           <= 1'b0;
            udf           <= 1'b0;
            sym_idx       <= '0;
            cw_acc        <= '0;
        end else begin
            sym_err <= mis;
            cw_done <= last;
            if (ref_valid && fifo_full && !dut_valid) ovf <= 1'b1;
            if (dut_valid && fifo_empty)              udf <= 1'b1;
            if (mis && (total_sym_err != '1)) total_sym_err <= total_sym_err + CNT_W'(1);
            if (last) begin
                sym_idx    <= '0;
                cw_acc     <= '0;
                cw_err_cnt <= acc_next;
                if (total_cw != '1) total_cw <= total_cw + CNT_W'(1);
                if ((acc_next != '0) && (total_bad_cw != '1)) total_bad_cw <= total_bad_cw + CNT_W'(1);
            end else if (dut_valid) begin
                sym_idx <= sym_idx + IDX_W'(1);
                cw_acc  <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_rs_stream_checker.sv
// Randomised bench for rs_stream_checker against a queue-based reference model.
// Counters are narrowed so that saturation is reachable in a short run.
module tb_rs_stream_checker;
    localparam int SYM_W = 8;
    localparam int K     = 188;
    localparam int DEPTH = 256;
    localparam int CNT_W = 6;
    localparam int ERR_W = $clog2(K+1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             Clk;
    logic             Reset;
    logic             ref_valid;
    logic [SYM_W-1:0] ref_sym;
    logic             dut_valid;
    logic [SYM_W-1:0] dut_sym;
    logic             sym_err;
    logic             cw_done;
    logic [ERR_W-1:0] cw_err_cnt;
    logic [CNT_W-1:0] total_cw;
    logic [CNT_W-1:0] total_bad_cw;
    logic [CNT_W-1:0] total_sym_err;
    logic             ovf;
    logic             udf;

    rs_stream_checker #(
        .SYM_W (SYM_W),
        .K     (K),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ref_valid     (ref_valid),
        .ref_sym       (ref_sym),
        .dut_valid     (dut_valid),
        .dut_sym       (dut_sym),
        .sym_err       (sym_err),
        .cw_done       (cw_done),
        .cw_err_cnt    (cw_err_cnt),
        .total_cw      (total_cw),
        .total_bad_cw  (total_bad_cw),
        .total_sym_err (total_sym_err),
        .ovf           (ovf),
        .udf           (udf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model state
    logic [SYM_W-1:0] m_q[$];
    int               m_idx;
    int               m_acc;
    int               m_cw_err;
    logic [CNT_W-1:0] m_total_cw;
    logic [CNT_W-1:0] m_total_bad;
    logic [CNT_W-1:0] m_total_sym;
    bit               m_ovf;
    bit               m_udf;

    int checks;
    int errors;
    int pulse_bad;
    int n_sym_pulse;
    int n_done_pulse;
    int cyc;
    int done_cyc[$];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CMAX) ? x : x + 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_idx = 0; m_acc = 0; m_cw_err = 0;
        m_total_cw = '0; m_total_bad = '0; m_total_sym = '0;
        m_ovf = 0; m_udf = 0;
        pulse_bad = 0; n_sym_pulse = 0; n_done_pulse = 0; cyc = 0;
        done_cyc.delete();
    endtask

    // One clock cycle of stimulus; advances the model and tallies pulse activity.
    task automatic drive(input bit rv, input logic [SYM_W-1:0] rs, input bit dv, input logic [SYM_W-1:0] ds);
        bit mis;
        bit done;
        ref_valid = rv; ref_sym = rs; dut_valid = dv; dut_sym = ds;
        mis = 0; done = 0;
        if (dv) begin
            if (m_q.size() == 0) begin
                mis = 1; m_udf = 1;
            end else begin
                mis = (m_q.pop_front() != ds);
            end
        end
        if (rv) begin
            if (m_q.size() < DEPTH) m_q.push_back(rs);
            else m_ovf = 1;
        end
        if (dv) begin
            m_acc += int'(mis);
            if (mis) m_total_sym = sat_inc(m_total_sym);
            m_idx++;
            if (m_idx == K) begin
                done = 1;
                m_cw_err = m_acc;
                m_total_cw = sat_inc(m_total_cw);
                if (m_acc != 0) m_total_bad = sat_inc(m_total_bad);
                m_acc = 0; m_idx = 0;
            end
        end
        @(posedge Clk);
        #1;
        cyc++;
        if (sym_err !== mis)  pulse_bad++;
        if (cw_done !== done) pulse_bad++;
        if (sym_err === 1'b1) n_sym_pulse++;
        if (cw_done === 1'b1) begin
            n_done_pulse++;
            done_cyc.push_back(cyc);
        end
        @(negedge Clk);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        ref_valid = 0; ref_sym = '0; dut_valid = 0; dut_sym = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ref_valid = 0; ref_sym = '0; dut_valid = 0; dut_sym = '0;
        #2;
        checks++;
        if ({sym_err, cw_done, ovf, udf} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {sym_err, cw_done, ovf, udf});
        end
        checks++;
        if (total_cw !== '0 || total_bad_cw !== '0 || total_sym_err !== '0 || cw_err_cnt !== '0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0", total_cw, total_bad_cw, total_sym_err, cw_err_cnt);
        end
        apply_reset();
        repeat (3) drive(0, '0, 0, '0);
        checks++;
        if (total_cw !== '0 || ovf !== 1'b0 || udf !== 1'b0 || pulse_bad != 0) begin
            errors++; $display("FAIL reset_idle got cw=%0d ovf=%b udf=%b pulses=%0d want 0", total_cw, ovf, udf, pulse_bad);
        end
    endtask

    task automatic test_clean_cw();
        apply_reset();
        for (int i = 0; i < K; i++) drive(1, SYM_W'(i), 0, '0);
        for (int i = 0; i < K; i++) begin
            drive(0, '0, 1, SYM_W'(i));
            repeat (3) drive(0, '0, 0, '0);
        end
        checks++;
        if (n_done_pulse != 1 || n_sym_pulse != 0 || pulse_bad != 0) begin
            errors++; $display("FAIL clean_pulses got done=%0d sym=%0d bad=%0d want 1/0/0", n_done_pulse, n_sym_pulse, pulse_bad);
        end
        checks++;
        if (cw_err_cnt !== ERR_W'(m_cw_err) || total_cw !== m_total_cw || total_bad_cw !== m_total_bad) begin
            errors++; $display("FAIL clean_counts got %0d/%0d/%0d want %0d/%0d/%0d",
                               cw_err_cnt, total_cw, total_bad_cw, m_cw_err, m_total_cw, m_total_bad);
        end
    endtask

    task automatic test_errors();
        logic [SYM_W-1:0] d[K];
        apply_reset();
        for (int i = 0; i < K; i++) begin
            d[i] = SYM_W'($urandom);
            drive(1, d[i], 0, '0);
        end
        for (int i = 0; i < K; i++) begin
            drive(0, '0, 1, d[i] ^ SYM_W'(i == 5 || i == 100 || i == 187));
            if ($urandom_range(0, 1) == 1) drive(0, '0, 0, '0);
        end
        checks++;
        if (n_sym_pulse != 3 || pulse_bad != 0) begin
            errors++; $display("FAIL err_pulses got sym=%0d bad=%0d want 3/0", n_sym_pulse, pulse_bad);
        end
        checks++;
        if (cw_err_cnt !== ERR_W'(3)) begin
            errors++; $display("FAIL err_cw_cnt got %0d want 3", cw_err_cnt);
        end
        checks++;
        if (total_sym_err !== m_total_sym || total_bad_cw !== m_total_bad || total_cw !== m_total_cw) begin
            errors++; $display("FAIL err_totals got %0d/%0d/%0d want %0d/%0d/%0d",
                               total_sym_err, total_bad_cw, total_cw, m_total_sym, m_total_bad, m_total_cw);
        end
    endtask

    task automatic test_overflow();
        logic [SYM_W-1:0] d[DEPTH+1];
        apply_reset();
        for (int i = 0; i <= DEPTH; i++) d[i] = SYM_W'($urandom);
        for (int i = 0; i <= DEPTH; i++) drive(1, d[i], 0, '0);
        checks++;
        if (ovf !== 1'b1 || udf !== 1'b0) begin
            errors++; $display("FAIL ovf_set got ovf=%b udf=%b want 1/0", ovf, udf);
        end
        for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, d[i]);
        checks++;
        if (n_sym_pulse != 0 || pulse_bad != 0 || total_sym_err !== '0 || udf !== 1'b0) begin
            errors++; $display("FAIL ovf_content got sym=%0d bad=%0d tot=%0d udf=%b want 0/0/0/0",
                               n_sym_pulse, pulse_bad, total_sym_err, udf);
        end
        // Full plus simultaneous pop: both proceed, no overflow.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) drive(1, d[i], 0, '0);
        drive(1, d[DEPTH], 1, d[0]);
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL full_pushpop_ovf got %b want 0", ovf);
        end
        for (int i = 1; i <= DEPTH; i++) drive(0, '0, 1, d[i]);
        checks++;
        if (n_sym_pulse != 0 || pulse_bad != 0 || ovf !== 1'b0 || udf !== 1'b0) begin
            errors++; $display("FAIL full_pushpop_data got sym=%0d bad=%0d ovf=%b udf=%b want 0/0/0/0",
                               n_sym_pulse, pulse_bad, ovf, udf);
        end
    endtask

    task automatic test_underflow();
        logic [SYM_W-1:0] s;
        apply_reset();
        s = SYM_W'($urandom);
        drive(1, s, 1, s);
        checks++;
        if (udf !== 1'b1 || sym_err !== 1'b1 || total_sym_err !== CNT_W'(1)) begin
            errors++; $display("FAIL udf_set got udf=%b sym_err=%b tot=%0d want 1/1/1", udf, sym_err, total_sym_err);
        end
        drive(0, '0, 1, s);
        checks++;
        if (n_sym_pulse != 1 || total_sym_err !== m_total_sym || udf !== 1'b1 || pulse_bad != 0) begin
            errors++; $display("FAIL udf_next_pop got pulses=%0d tot=%0d udf=%b bad=%0d want 1/%0d/1/0",
                               n_sym_pulse, total_sym_err, udf, pulse_bad, m_total_sym);
        end
    endtask

    task automatic test_async_reset();
        logic [SYM_W-1:0] d[K];
        apply_reset();
        drive(0, '0, 1, '0);
        for (int i = 0; i < K; i++) begin
            d[i] = SYM_W'($urandom);
            drive(1, d[i], 0, '0);
        end
        for (int i = 0; i < 100; i++) drive(0, '0, 1, d[i] ^ SYM_W'($urandom_range(0, 3) == 0));
        drive(0, '0, 1, ~d[100]);
        checks++;
        if (udf !== 1'b1 || sym_err !== 1'b1) begin
            errors++; $display("FAIL pre_async got udf=%b sym_err=%b want 1/1", udf, sym_err);
        end
        #3;
        Reset = 1'b1;
        #1;
        checks++;
        if ({sym_err, cw_done, ovf, udf} !== 4'b0000 || total_sym_err !== '0 || total_cw !== '0 ||
            total_bad_cw !== '0 || cw_err_cnt !== '0) begin
            errors++; $display("FAIL async_reset got flags=%b tot_sym=%0d tot_cw=%0d bad=%0d cnt=%0d want 0",
                               {sym_err, cw_done, ovf, udf}, total_sym_err, total_cw, total_bad_cw, cw_err_cnt);
        end
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        for (int i = 0; i < K; i++) drive(1, d[i], 0, '0);
        for (int i = 0; i < K; i++) drive(0, '0, 1, d[i]);
        checks++;
        if (total_cw !== CNT_W'(1) || cw_err_cnt !== '0 || n_done_pulse != 1 || pulse_bad != 0) begin
            errors++; $display("FAIL post_reset_cw got cw=%0d cnt=%0d done=%0d bad=%0d want 1/0/1/0",
                               total_cw, cw_err_cnt, n_done_pulse, pulse_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [SYM_W-1:0] prev;
        logic [SYM_W-1:0] nxt;
        int err_pos;
        int bad_gaps;
        apply_reset();
        prev = SYM_W'($urandom);
        drive(1, prev, 0, '0);
        for (int c = 0; c < 10; c++) begin
            err_pos = $urandom_range(0, K-1);
            for (int i = 0; i < K; i++) begin
                nxt = SYM_W'($urandom);
                drive((c != 9 || i != K-1), nxt, 1, prev ^ SYM_W'(i == err_pos));
                prev = nxt;
            end
        end
        bad_gaps = 0;
        for (int i = 1; i < done_cyc.size(); i++) if (done_cyc[i] - done_cyc[i-1] != K) bad_gaps++;
        checks++;
        if (n_done_pulse != 10 || bad_gaps != 0 || pulse_bad != 0) begin
            errors++; $display("FAIL b2b_pulses got done=%0d bad_gaps=%0d bad=%0d want 10/0/0", n_done_pulse, bad_gaps, pulse_bad);
        end
        checks++;
        if (total_cw !== CNT_W'(10) || total_bad_cw !== CNT_W'(10) || total_sym_err !== CNT_W'(10)) begin
            errors++; $display("FAIL b2b_totals got %0d/%0d/%0d want 10/10/10", total_cw, total_bad_cw, total_sym_err);
        end
    endtask

    task automatic test_random();
        bit rv;
        bit dv;
        logic [SYM_W-1:0] ds;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            rv = ($urandom_range(0, 99) < 70);
            dv = ($urandom_range(0, 99) < 65);
            if (m_q.size() != 0) ds = m_q[0] ^ SYM_W'($urandom_range(0, 7) == 0);
            else ds = SYM_W'($urandom);
            drive(rv, SYM_W'($urandom), dv, ds);
        end
        checks++;
        if (pulse_bad != 0) begin
            errors++; $display("FAIL rand_pulses got %0d pulse deviations want 0", pulse_bad);
        end
        checks++;
        if (total_sym_err !== m_total_sym || total_cw !== m_total_cw || total_bad_cw !== m_total_bad) begin
            errors++; $display("FAIL rand_totals got %0d/%0d/%0d want %0d/%0d/%0d",
                               total_sym_err, total_cw, total_bad_cw, m_total_sym, m_total_cw, m_total_bad);
        end
        checks++;
        if (cw_err_cnt !== ERR_W'(m_cw_err) || ovf !== m_ovf || udf !== m_udf) begin
            errors++; $display("FAIL rand_state got cnt=%0d ovf=%b udf=%b want %0d/%b/%b",
                               cw_err_cnt, ovf, udf, m_cw_err, m_ovf, m_udf);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_clean_cw();
        test_errors();
        test_overflow();
        test_underflow();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "simulation did not complete");
    end
endmodule
